// File: rtl/msrv32_integer_file.sv
// rtl/msrv32_integer_file.sv - RV32 integer register file with post-reset clear sweep
// Optional write-through read bypass: define MSRV32_RF_BYPASS_EN.
module msrv32_integer_file #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic [$clog2(NUM_REGS)-1:0] rs_1_addr_in,
   input  logic [$clog2(NUM_REGS)-1:0] rs_2_addr_in,
   input  logic [$clog2(NUM_REGS)-1:0] rd_addr_in,
   input  logic                        wr_en_in,
   input  logic [XLEN-1:0]             rd_in,
   output logic [XLEN-1:0]             rs_1_out,
   output logic [XLEN-1:0]             rs_2_out,
   output logic                        init_done_out
);

   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_ptr;
   logic [AW-1:0]   w_ptr_nxt;
   logic            r_init_done;
   logic            w_init_done_nxt;
   logic            w_clr_en;
   logic            w_usr_wr;
   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic [XLEN-1:0] w_rs_1;
   logic [XLEN-1:0] w_rs_2;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state     <= S_INIT;
         r_ptr       <= AW'(1);
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_init_done_nxt = r_init_done;
      w_clr_en        = 1'b0;
      w_usr_wr        = 1'b0;
      case (r_state)
         S_INIT: begin
            w_clr_en  = 1'b1;
            w_ptr_nxt = r_ptr + AW'(1);
            // Clearing the last register completes the sweep on this edge.
            if (r_ptr == AW'(NUM_REGS - 1)) begin
               w_state_nxt     = S_READY;
               w_init_done_nxt = 1'b1;
            end
         end
         S_READY: begin
            w_usr_wr = wr_en_in && (rd_addr_in != '0);
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   // Storage has no reset; the sweep is what brings it to a known value.
   always_ff @(posedge clk_in) begin
      if (rst_n_in) begin
         if (w_clr_en) begin
            r_regs[r_ptr] <= '0;
         end else if (w_usr_wr) begin
            r_regs[rd_addr_in] <= rd_in;
         end
      end
   end

   always_comb begin
      w_rs_1 = '0;
      w_rs_2 = '0;
      if (r_state == S_READY) begin
         if (rs_1_addr_in != '0) begin
            w_rs_1 = r_regs[rs_1_addr_in];
         end
         if (rs_2_addr_in != '0) begin
            w_rs_2 = r_regs[rs_2_addr_in];
         end
`ifdef MSRV32_RF_BYPASS_EN
         if (w_usr_wr && (rd_addr_in == rs_1_addr_in)) begin
            w_rs_1 = rd_in;
         end
         if (w_usr_wr && (rd_addr_in == rs_2_addr_in)) begin
            w_rs_2 = rd_in;
         end
`endif
      end
   end

   assign rs_1_out      = w_rs_1;
   assign rs_2_out      = w_rs_2;
   assign init_done_out = r_init_done;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb/tb_msrv32_integer_file.sv - randomized self-checking bench for msrv32_integer_file
module tb_msrv32_integer_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_1_addr;
   logic [4:0]  rs_2_addr;
   logic [4:0]  rd_addr;
   logic        wr_en;
   logic [31:0] rd_data;
   logic [31:0] rs_1_data;
   logic [31:0] rs_2_data;
   logic        init_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: architectural register values plus sweep progress.
   logic [31:0] m_regs [32];
   bit          m_known = 0;
   bit          m_ready = 0;
   int          m_edges = 0;

   msrv32_integer_file dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .rs_1_addr_in  (rs_1_addr),
      .rs_2_addr_in  (rs_2_addr),
      .rd_addr_in    (rd_addr),
      .wr_en_in      (wr_en),
      .rd_in         (rd_data),
      .rs_1_out      (rs_1_data),
      .rs_2_out      (rs_2_data),
      .init_done_out (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit w,
                                            input logic [4:0] rd, input logic [31:0] d);
      if (!m_ready || a == 5'd0) return 32'h0;
`ifdef MSRV32_RF_BYPASS_EN
      if (w && rd == a) return d;
`endif
      return m_regs[a];
   endfunction

   // One clock: drive inputs, check combinational outputs mid-cycle, advance model on the edge.
   task automatic cycle(input bit rst, input bit w, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
      rst_n     = rst;
      wr_en     = w;
      rd_addr   = rd;
      rd_data   = d;
      rs_1_addr = a1;
      rs_2_addr = a2;
      #3;
      if (m_known) begin
         check($sformatf("rs1[x%0d]", a1), rs_1_data, exp_read(a1, w, rd, d));
         check($sformatf("rs2[x%0d]", a2), rs_2_data, exp_read(a2, w, rd, d));
         check($sformatf("init_done@%0d", m_edges), {31'd0, init_done}, {31'd0, m_ready});
      end
      @(posedge clk);
      if (!rst) begin
         m_known = 1;
         m_ready = 0;
         m_edges = 0;
      end else if (!m_ready) begin
         m_edges++;
         if (m_edges == 31) begin
            m_ready = 1;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         end
      end else if (w && rd != 5'd0) begin
         m_regs[rd] = d;
      end
      #1;
   endtask

   task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, a1, a2);
   endtask

   task automatic rand_init_cycles(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'b1, ($urandom_range(0, 3) == 0) ? 5'd3 : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? 32'h5 : $urandom, 5'($urandom), 5'($urandom));
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_addr = '0; rd_data = '0; rs_1_addr = '0; rs_2_addr = '0;
      #1;

      // Reset held for 3 edges, then the sweep with random writes that must be ignored.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'd3, 32'h5, 5'd3, 5'd1);
      rand_init_cycles(31);
      for (int a = 0; a < 32; a += 2) idle_read(5'(a), 5'(a + 1));

      // Basic write/read.
      cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
      cycle(1'b1, 1'b1, 5'd31, 32'h12345678, 5'd1, 5'd2);
      idle_read(5'd5, 5'd31);
      check("x5_direct", rs_1_data, 32'hDEADBEEF);
      check("x31_direct", rs_2_data, 32'h12345678);

      // x0 protection.
      cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      idle_read(5'd0, 5'd0);
      check("x0_direct", rs_1_data, 32'h0);

      // Gated write.
      cycle(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
      cycle(1'b1, 1'b0, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
      idle_read(5'd7, 5'd0);
      check("x7_gated", rs_1_data, 32'h11111111);

      // Same-cycle read/write of x9.
      cycle(1'b1, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
      cycle(1'b1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
      idle_read(5'd9, 5'd9);
      check("x9_after", rs_1_data, 32'h2);

      // Reset mid-sweep, then writes to x3 during the restarted sweep.
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
      rand_init_cycles(9);
      cycle(1'b0, 1'b1, 5'd3, 32'h5, 5'd3, 5'd9);
      for (int i = 0; i < 31; i++) cycle(1'b1, 1'b1, 5'd3, 32'h5, 5'd3, 5'd9);
      idle_read(5'd3, 5'd9);
      check("x3_after_init", rs_1_data, 32'h0);

      // Random traffic with forced address collisions and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] rd;
         logic [4:0] a1;
         logic [4:0] a2;
         rd = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         cycle(($urandom_range(0, 799) != 0), ($urandom_range(0, 2) != 0), rd, $urandom, a1, a2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
